// File: rtl/mpu_pkg.sv
// Shared MPU definitions: matrix geometry, flattened widths, loader states and
// the column-major flat-index helper used by the loader, multiplier and display tasks.
package mpu_pkg;

    localparam int MPU_DIM      = 5;
    localparam int MPU_ELEM8_W  = 8;
    localparam int MPU_ELEM16_W = 16;
    localparam int MPU_FLAT8_W  = MPU_DIM * MPU_DIM * MPU_ELEM8_W;
    localparam int MPU_FLAT16_W = MPU_DIM * MPU_DIM * MPU_ELEM16_W;

    typedef enum logic [1:0] {
        LD_IDLE   = 2'd0,
        LD_LOAD_A = 2'd1,
        LD_LOAD_B = 2'd2,
        LD_FULL   = 2'd3
    } ld_state_e;

    // Element (i,j) lives at flat index j*dim+i (column-major).
    function automatic int unsigned flat_idx(input int unsigned i,
                                             input int unsigned j,
                                             input int unsigned dim);
        return j * dim + i;
    endfunction

endpackage

// File: rtl/mpu_elem_counter.sv
// Row/column position counter for a row-major NxN element stream;
// wraps to (0,0) after the last element.
module mpu_elem_counter #(
    parameter int DIM = 5,
    parameter int CW  = $clog2(DIM),
    parameter int NW  = $clog2(DIM + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [NW-1:0] n_i,
    input  logic          advance_i,
    input  logic          clear_i,
    output logic [CW-1:0] r_o,
    output logic [CW-1:0] c_o,
    output logic          last_o
);

    logic [CW-1:0] r_q;
    logic [CW-1:0] c_q;
    logic [NW-1:0] n_m1_s;
    logic          c_end_s;

    assign n_m1_s  = n_i - NW'(1);
    assign c_end_s = (NW'(c_q) == n_m1_s);
    assign last_o  = c_end_s && (NW'(r_q) == n_m1_s);
    assign r_o     = r_q;
    assign c_o     = c_q;

    // Position update: column steps first, row steps on column wrap.
    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            r_q <= '0;
            c_q <= '0;
        end else if (advance_i) begin
            if (last_o) begin
                r_q <= '0;
                c_q <= '0;
            end else if (c_end_s) begin
                r_q <= r_q + CW'(1);
                c_q <= '0;
            end else begin
                c_q <= c_q + CW'(1);
            end
        end
    end

endmodule

// File: rtl/mpu_matrix_loader.sv
// Assembles a row-major byte stream into column-major flattened A and B
// matrices and hands both to the multiplier over a valid/ready handshake.
module mpu_matrix_loader
    import mpu_pkg::*;
#(
    parameter int DIM    = MPU_DIM,
    parameter int ELEM_W = MPU_ELEM8_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [7:0]                size,
    input  logic                      in_valid,
    input  logic [ELEM_W-1:0]         in_data,
    output logic                      in_ready,
    output logic [DIM*DIM*ELEM_W-1:0] matrix_a,
    output logic [DIM*DIM*ELEM_W-1:0] matrix_b,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      busy,
    output logic                      err
);

    localparam int CW     = $clog2(DIM);
    localparam int NW     = $clog2(DIM + 1);
    localparam int FLAT_W = DIM * DIM * ELEM_W;

    ld_state_e         state_q, state_d;
    logic [NW-1:0]     n_q, n_d;
    logic [FLAT_W-1:0] mat_a_q, mat_a_d;
    logic [FLAT_W-1:0] mat_b_q, mat_b_d;
    logic              err_q, err_d;

    logic [CW-1:0]     r_s;
    logic [CW-1:0]     c_s;
    logic              last_s;
    logic              load_s;
    logic              xfer_s;
    logic              clr_s;
    logic              size_ok_s;
    int unsigned       wr_lsb_s;

    assign load_s    = (state_q == LD_LOAD_A) || (state_q == LD_LOAD_B);
    assign xfer_s    = load_s && in_valid;
    assign size_ok_s = (size != 8'd0) && (size <= 8'(DIM));
    assign wr_lsb_s  = flat_idx(32'(r_s), 32'(c_s), DIM) * ELEM_W;

    assign in_ready  = load_s;
    assign out_valid = (state_q == LD_FULL);
    assign busy      = (state_q != LD_IDLE);
    assign err       = err_q;
    assign matrix_a  = mat_a_q;
    assign matrix_b  = mat_b_q;

    mpu_elem_counter #(
        .DIM (DIM),
        .CW  (CW),
        .NW  (NW)
    ) u_cnt (
        .clk       (clk),
        .rst       (rst),
        .n_i       (n_q),
        .advance_i (xfer_s),
        .clear_i   (clr_s),
        .r_o       (r_s),
        .c_o       (c_s),
        .last_o    (last_s)
    );

    // Next-state, matrix write and error-pulse decode.
    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        mat_a_d = mat_a_q;
        mat_b_d = mat_b_q;
        err_d   = 1'b0;
        clr_s   = 1'b0;
        case (state_q)
            LD_IDLE: begin
                if (start && size_ok_s) begin
                    n_d     = size[NW-1:0];
                    mat_a_d = '0;
                    mat_b_d = '0;
                    clr_s   = 1'b1;
                    state_d = LD_LOAD_A;
                end else if (start) begin
                    err_d   = 1'b1;
                end else begin
                    state_d = LD_IDLE;
                end
            end
            LD_LOAD_A: begin
                if (xfer_s) begin
                    mat_a_d[wr_lsb_s +: ELEM_W] = in_data;
                    state_d = last_s ? LD_LOAD_B : LD_LOAD_A;
                end else begin
                    state_d = LD_LOAD_A;
                end
            end
            LD_LOAD_B: begin
                if (xfer_s) begin
                    mat_b_d[wr_lsb_s +: ELEM_W] = in_data;
                    state_d = last_s ? LD_FULL : LD_LOAD_B;
                end else begin
                    state_d = LD_LOAD_B;
                end
            end
            LD_FULL: begin
                if (out_ready) begin
                    state_d = LD_IDLE;
                end else begin
                    state_d = LD_FULL;
                end
            end
            default: begin
                state_d = LD_IDLE;
            end
        endcase
    end

    // Registered FSM state, active size and matrix storage.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LD_IDLE;
            n_q     <= '0;
            mat_a_q <= '0;
            mat_b_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            mat_a_q <= mat_a_d;
            mat_b_q <= mat_b_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_mpu_matrix_loader.sv
// Directed/randomized bench for mpu_matrix_loader against a 2-D array model
// of the A and B matrices.
module tb_mpu_matrix_loader;

    localparam int D = 5;
    localparam int W = 8;
    localparam int FW = D * D * W;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [7:0]    size = 8'd0;
    logic          in_valid = 1'b0;
    logic [W-1:0]  in_data = '0;
    logic          in_ready;
    logic [FW-1:0] matrix_a;
    logic [FW-1:0] matrix_b;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          busy;
    logic          err;

    int errors = 0;
    int checks = 0;

    logic [7:0] ref_a [D][D];
    logic [7:0] ref_b [D][D];
    logic [7:0] sdata [2*D*D];
    logic [FW-1:0] snap_a, snap_b;
    logic [7:0] elem;

    mpu_matrix_loader #(.DIM(D), .ELEM_W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .size      (size),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .matrix_a  (matrix_a),
        .matrix_b  (matrix_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_vec(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < D; i++)
            for (int j = 0; j < D; j++) begin
                ref_a[i][j] = 8'd0;
                ref_b[i][j] = 8'd0;
            end
    endtask

    // Column-major image of a model matrix: element (i,j) at (j*D+i)*W.
    function automatic logic [FW-1:0] pack(input bit which_b);
        logic [FW-1:0] v = '0;
        for (int i = 0; i < D; i++)
            for (int j = 0; j < D; j++)
                v[(j*D+i)*W +: W] = which_b ? ref_b[i][j] : ref_a[i][j];
        return v;
    endfunction

    task automatic check_mats(input string tag);
        chk_vec({tag, "_a"}, matrix_a, pack(1'b0));
        chk_vec({tag, "_b"}, matrix_b, pack(1'b1));
    endtask

    task automatic check_idle_zero(input string tag);
        chk_bit({tag, "_busy"}, busy, 1'b0);
        chk_bit({tag, "_in_ready"}, in_ready, 1'b0);
        chk_bit({tag, "_out_valid"}, out_valid, 1'b0);
        chk_bit({tag, "_err"}, err, 1'b0);
        chk_vec({tag, "_a_zero"}, matrix_a, '0);
        chk_vec({tag, "_b_zero"}, matrix_b, '0);
    endtask

    task automatic do_start(input int s);
        start = 1'b1;
        size  = 8'(s);
        tick();
        start = 1'b0;
        if (s >= 1 && s <= D) clear_model();
    endtask

    // Streams sdata[0..count-1]; every accepted element updates the model.
    task automatic run_stream(input int n, input int count, input bit gaps);
        int k = 0;
        int budget = 0;
        logic rdy;
        while (k < count && budget < 4000) begin
            in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            in_data  = sdata[k];
            rdy      = in_ready;
            chk_int("load_rdy_vld", {30'd0, in_ready, out_valid}, 2);
            tick();
            if (in_valid && rdy) begin
                if (k < n*n) ref_a[k/n][k%n] = sdata[k];
                else         ref_b[(k-n*n)/n][(k-n*n)%n] = sdata[k];
                k++;
            end
            budget++;
        end
        in_valid = 1'b0;
        chk_int("stream_count", k, count);
    endtask

    initial begin
        clear_model();
        tick();
        tick();
        rst = 1'b0;
        check_idle_zero("reset");

        // Full 5x5: A = 1..25, B = identity.
        for (int k = 0; k < 25; k++) begin
            sdata[k]      = 8'(k + 1);
            sdata[25 + k] = (k / 5 == k % 5) ? 8'd1 : 8'd0;
        end
        do_start(5);
        chk_bit("start_busy", busy, 1'b1);
        chk_bit("start_in_ready", in_ready, 1'b1);
        run_stream(5, 50, 1'b0);
        chk_bit("full5_out_valid", out_valid, 1'b1);
        chk_bit("full5_in_ready", in_ready, 1'b0);
        check_mats("full5");
        elem = matrix_a[(3*5+4)*8 +: 8];
        chk_int("full5_a43", int'(elem), 5*4 + 3 + 1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk_bit("full5_done_valid", out_valid, 1'b0);
        chk_bit("full5_done_busy", busy, 1'b0);

        // Reduced 3x3 with out_ready held high throughout the load.
        for (int k = 0; k < 9; k++) begin
            sdata[k]     = 8'(k + 1);
            sdata[9 + k] = 8'(9 - k);
        end
        out_ready = 1'b1;
        do_start(3);
        run_stream(3, 18, 1'b0);
        chk_bit("red3_out_valid", out_valid, 1'b1);
        check_mats("red3");
        elem = matrix_a[(2*5+1)*8 +: 8];
        chk_int("red3_a12", int'(elem), 6);
        elem = matrix_b[(0*5+2)*8 +: 8];
        chk_int("red3_b20", int'(elem), 3);
        tick();
        out_ready = 1'b0;
        chk_bit("red3_done_valid", out_valid, 1'b0);

        // Random 5x5 data with in_valid gaps, then 10 cycles of backpressure.
        for (int k = 0; k < 50; k++) sdata[k] = 8'($urandom_range(0, 255));
        do_start(5);
        run_stream(5, 50, 1'b1);
        check_mats("gap5");
        for (int c = 0; c < 10; c++) begin
            if (c == 4) begin
                start = 1'b1;
                size  = 8'd2;
            end else begin
                start = 1'b0;
            end
            tick();
            chk_bit("bp_out_valid", out_valid, 1'b1);
            chk_bit("bp_in_ready", in_ready, 1'b0);
        end
        start = 1'b0;
        check_mats("bp_hold");
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk_bit("bp_done_busy", busy, 1'b0);

        // Rejected sizes pulse err for one cycle and leave matrices alone.
        snap_a = pack(1'b0);
        snap_b = pack(1'b1);
        do_start(0);
        chk_bit("bad0_err", err, 1'b1);
        chk_bit("bad0_busy", busy, 1'b0);
        tick();
        chk_bit("bad0_err_clr", err, 1'b0);
        do_start(6);
        chk_bit("bad6_err", err, 1'b1);
        chk_bit("bad6_busy", busy, 1'b0);
        tick();
        chk_bit("bad6_err_clr", err, 1'b0);
        chk_vec("bad_a_same", matrix_a, snap_a);
        chk_vec("bad_b_same", matrix_b, snap_b);

        // Reset after 7 B transfers of a 4x4 load.
        for (int k = 0; k < 32; k++) sdata[k] = 8'($urandom_range(1, 255));
        do_start(4);
        run_stream(4, 16 + 7, 1'b0);
        chk_bit("mid_busy", busy, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        clear_model();
        check_idle_zero("midrst");

        // A fresh 2x2 load after the reset.
        for (int k = 0; k < 8; k++) sdata[k] = 8'($urandom_range(1, 255));
        do_start(2);
        run_stream(2, 8, 1'b1);
        chk_bit("post2_out_valid", out_valid, 1'b1);
        check_mats("post2");
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk_bit("post2_done_busy", busy, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mpu_matrix_loader.md
# mpu_matrix_loader

Serial-to-flat matrix writer feeding the MPU multiplier datapath. Accepts a byte stream of operand elements over a valid/ready handshake, assembles matrix A then matrix B into the flattened column-major 5x5 layout the multiplier consumes, and presents both matrices with a valid/ready output handshake. Sits between the host/command interface and the combinational multiply core.

## Interface

- Clocking: one clock; reset is synchronous and active-high.
- Parameters:
  - `DIM`, 5: maximum matrix dimension.
  - `ELEM_W`, 8: element width in bits.
- Ports:
  - `clk` in 1: clock; all state updates on its rising edge.
  - `rst` in 1: reset, synchronous and active-high.
  - `start` in 1: begin a load; honoured only in IDLE.
  - `size` in 8: active dimension N, valid range 1..DIM; sampled with `start`.
  - `in_valid` in 1: `in_data` is valid.
  - `in_data` in ELEM_W: element value.
  - `in_ready` out 1: loader accepts an element this cycle.
  - `matrix_a` out DIM*DIM*ELEM_W: flattened A; element (i,j) at `[(j*DIM+i)*ELEM_W +: ELEM_W]`.
  - `matrix_b` out DIM*DIM*ELEM_W: flattened B; same layout as A.
  - `out_valid` out 1: both matrices complete and stable.
  - `out_ready` in 1: consumer accepts the matrices.
  - `busy` out 1: state is not IDLE.
  - `err` out 1: one-cycle pulse on a rejected `start`.

## Operation

- States: IDLE, LOAD_A, LOAD_B, FULL.
- IDLE:
  - On `start` with 1 <= `size` <= DIM: latch N, clear `matrix_a` and `matrix_b` to zero, reset row/col counters to 0, then go to LOAD_A.
  - On `start` with `size` = 0 or `size` > DIM: pulse `err`; state remains IDLE; matrices are unchanged.
- LOAD_A / LOAD_B:
  - `in_ready` = 1.
  - Transfer occurs when `in_valid` && `in_ready`.
  - Stream order is row-major: element (r,c) is written to flat index c*DIM+r.
  - After each transfer: c increments. When c = N-1, c wraps to 0 and r increments.
  - The transfer at (N-1,N-1) resets the counters and moves LOAD_A to LOAD_B, or LOAD_B to FULL.
- FULL:
  - `out_valid` = 1 and `in_ready` = 0.
  - On `out_ready`, go to IDLE.
  - Matrices hold their contents until the next accepted `start`.
- Elements with i >= N or j >= N stay zero. This keeps the DIM x DIM product correct in the top-left NxN corner.
- `start` is ignored outside IDLE.
- `in_valid` is ignored outside LOAD states; no data is buffered.
- No arithmetic; `in_data` is written verbatim.
- Counters are 3 bits for DIM=5 (generally clog2(DIM)). N is stored in clog2(DIM+1) bits.

## Timing

- Reset values:
  - State IDLE.
  - `in_ready` = 0, `out_valid` = 0, `busy` = 0, `err` = 0.
  - `matrix_a` = 0, `matrix_b` = 0, counters = 0, N = 0.
- Reset mid-operation (any state) returns to the reset values on the next edge. Partial loads are discarded.
- Outputs are registered or decoded from registered state only, so there is no combinational input-to-output path.
- Cycle timing:
  - Accepted `start` at edge t: `busy` and `in_ready` are 1 from cycle t+1.
  - Final B transfer at edge t: `out_valid` = 1 and `in_ready` = 0 from cycle t+1.
  - `out_ready` sampled high at edge t while FULL: `out_valid` = 0 from cycle t+1. A new `start` is accepted at edge t+1 at the earliest.
- Throughput: with `in_valid` held high, one element per cycle. Minimum load = 2·N² cycles plus 1 cycle `start` plus 1 cycle FULL.
- `in_valid` gaps stall the counters without side effects.
- `out_ready` high before FULL has no effect.
- `err` is high for exactly one cycle following the rejected `start` edge.

## Structure

- Shared package `mpu_pkg`:
  - `MPU_DIM` = 5.
  - `MPU_ELEM8_W` = 8 and `MPU_ELEM16_W` = 16.
  - Flattened-matrix width constants.
  - Loader state enum.
  - Flat-index helper (j*DIM+i), shared with the multiplier and display tasks.
- One sub-module: `mpu_elem_counter`, the row/col counter.
  - Inputs: N, advance, clear.
  - Outputs: r, c, last.

## Test plan

- Full 5x5 load:
  - `size`=5; A stream 1..25 row-major; B = identity stream.
  - After 50 transfers, `out_valid` rises the next cycle.
  - `matrix_a[(j*5+i)*8 +: 8]` = 5i+j+1.
  - B diagonal = 1, others 0.
  - `out_ready` pulse returns to IDLE, `busy`=0.
- Reduced 3x3 load:
  - `size`=3; A = 1..9, B = 9..1.
  - `out_valid` after 18 transfers.
  - A(1,2) = 6, B(2,0) = 3.
  - All entries with i>=3 or j>=3 = 0, including stale data from a prior 5x5 load.
- Backpressure and gaps:
  - `in_valid` toggled randomly; `out_ready` held low for 10 cycles in FULL.
  - Contents match the no-gap run.
  - `out_valid` stays 1 and `in_ready` stays 0 throughout.
  - `start` during FULL is ignored.
- Bad size:
  - `start` with `size`=0, then with `size`=6.
  - `err` pulses 1 cycle each; `busy` stays 0; matrices unchanged.
- Reset mid-load:
  - `rst` after 7 B transfers.
  - Next cycle all outputs and matrices = 0, state IDLE.
  - A subsequent 2x2 load completes correctly.
